// File: rtl/grf_write_arbiter_pkg.sv
// Shared constants and helpers for the grf write arbiter.
// Holds register-file geometry and pointer wrap arithmetic.
package grf_write_arbiter_pkg;

  localparam int GPR_N      = 32;
  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;

  localparam logic [4:0] REG_ZERO = 5'd0;

  function automatic int wrap_inc(
    input int p,
    input int depth
  );
    return (p + 1 >= depth) ? 0 : p + 1;
  endfunction

endpackage

// File: rtl/grf_write_arbiter_wb_queue.sv
// In-order {Rd,Data} writeback queue: two pushes and one pop per cycle.
// Per-entry valid bits and Rd fields are exposed for pending tracking.
module grf_write_arbiter_wb_queue
  import grf_write_arbiter_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int CW     = $clog2(DEPTH + 1)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push0_i,
  input  logic [ADDR_W-1:0]        rd0_i,
  input  logic [DATA_W-1:0]        data0_i,
  input  logic                     push1_i,
  input  logic [ADDR_W-1:0]        rd1_i,
  input  logic [DATA_W-1:0]        data1_i,
  input  logic                     pop_i,
  output logic [CW-1:0]            count_o,
  output logic [DEPTH-1:0]         vld_o,
  output logic [DEPTH*ADDR_W-1:0]  rds_o,
  output logic [ADDR_W-1:0]        head_rd_o,
  output logic [DATA_W-1:0]        head_data_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PW-1:0]     wr_q, wr_d;
  logic [PW-1:0]     rd_q, rd_d;
  logic [PW-1:0]     wr1, wr2, rd1;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [DEPTH-1:0]  vld_q, vld_d;
  logic [ADDR_W-1:0] rdm_q [DEPTH];
  logic [DATA_W-1:0] dat_q [DEPTH];

  assign wr1 = PW'(wrap_inc(int'(wr_q), DEPTH));
  assign wr2 = PW'(wrap_inc(int'(wr1), DEPTH));
  assign rd1 = PW'(wrap_inc(int'(rd_q), DEPTH));

  always_comb begin
    vld_d = vld_q;
    if (pop_i)   vld_d[rd_q] = 1'b0;
    if (push0_i) vld_d[wr_q] = 1'b1;
    if (push1_i) vld_d[wr1]  = 1'b1;
    rd_d  = pop_i ? rd1 : rd_q;
    wr_d  = push1_i ? wr2 : (push0_i ? wr1 : wr_q);
    cnt_d = cnt_q + CW'(push0_i)
          + CW'(push1_i) - CW'(pop_i);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      vld_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
      vld_q <= vld_d;
    end
  end

  // Payload needs no reset: an entry is only observed while its valid bit is set.
  always_ff @(posedge clk_i) begin
    if (push0_i) begin
      rdm_q[wr_q] <= rd0_i;
      dat_q[wr_q] <= data0_i;
    end
    if (push1_i) begin
      rdm_q[wr1] <= rd1_i;
      dat_q[wr1] <= data1_i;
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_rds
    assign rds_o[i*ADDR_W +: ADDR_W] = rdm_q[i];
  end

  assign count_o     = cnt_q;
  assign vld_o       = vld_q;
  assign head_rd_o   = (cnt_q != '0) ? rdm_q[rd_q] : '0;
  assign head_data_o = (cnt_q != '0) ? dat_q[rd_q] : '0;

endmodule

// File: rtl/grf_write_arbiter.sv
// Merges pipeline (A) and mult/div (B) results into the single grf write port.
// A is always enqueued ahead of B; Rd==0 results are accepted and dropped.
module grf_write_arbiter
  import grf_write_arbiter_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              A_Valid,
  input  logic [ADDR_W-1:0] A_Rd,
  input  logic [DATA_W-1:0] A_Data,
  output logic              A_Ready,
  input  logic              B_Valid,
  input  logic [ADDR_W-1:0] B_Rd,
  input  logic [DATA_W-1:0] B_Data,
  output logic              B_Ready,
  output logic              RegWrite,
  output logic [ADDR_W-1:0] RD,
  output logic [DATA_W-1:0] WData,
  output logic [GPR_N-1:0]  Pending
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [CW-1:0]           count;
  logic [DEPTH-1:0]        vld;
  logic [DEPTH*ADDR_W-1:0] rds;
  logic [ADDR_W-1:0]       head_rd;
  logic [DATA_W-1:0]       head_data;
  logic                    head_vld;
  logic                    a_push, b_push;
  logic                    push0, push1;
  logic [ADDR_W-1:0]       rd0;
  logic [DATA_W-1:0]       data0;
  logic [GPR_N-1:0]        pend;

  // B needs two free slots so a joint A+B transfer can never overflow.
  assign A_Ready = !Reset && (count < CW'(DEPTH));
  assign B_Ready = !Reset && (count < CW'(DEPTH - 1));

  assign a_push = A_Valid && A_Ready
               && (A_Rd != ADDR_W'(REG_ZERO));
  assign b_push = B_Valid && B_Ready
               && (B_Rd != ADDR_W'(REG_ZERO));

  assign push0 = a_push || b_push;
  assign push1 = a_push && b_push;
  assign rd0   = a_push ? A_Rd : B_Rd;
  assign data0 = a_push ? A_Data : B_Data;

  assign head_vld = (count != '0);

  grf_write_arbiter_wb_queue #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .CW     (CW)
  ) u_wb_queue (
    .clk_i       (Clk),
    .rst_i       (Reset),
    .push0_i     (push0),
    .rd0_i       (rd0),
    .data0_i     (data0),
    .push1_i     (push1),
    .rd1_i       (B_Rd),
    .data1_i     (B_Data),
    .pop_i       (head_vld),
    .count_o     (count),
    .vld_o       (vld),
    .rds_o       (rds),
    .head_rd_o   (head_rd),
    .head_data_o (head_data)
  );

  always_comb begin
    pend = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld[i])
        pend = pend | (GPR_N'(1) << rds[i*ADDR_W +: ADDR_W]);
    end
    pend[0] = 1'b0;
  end

  // Gating on Reset keeps in-flight entries from reaching the grf at the reset edge.
  assign RegWrite = !Reset && head_vld;
  assign RD       = RegWrite ? head_rd : '0;
  assign WData    = RegWrite ? head_data : '0;
  assign Pending  = Reset ? '0 : pend;

endmodule

// File: tb/tb_grf_write_arbiter.sv
// Self-checking bench for grf_write_arbiter against a queue-based reference.
// Directed scenarios followed by randomized traffic with occasional resets.
module tb_grf_write_arbiter;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        A_Valid, B_Valid;
  logic [4:0]  A_Rd, B_Rd;
  logic [31:0] A_Data, B_Data;
  logic        A_Ready, B_Ready;
  logic        RegWrite;
  logic [4:0]  RD;
  logic [31:0] WData;
  logic [31:0] Pending;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] d;
  } ent_t;

  ent_t q[$];

  always #5 Clk = ~Clk;

  grf_write_arbiter #(
    .DEPTH  (4),
    .DATA_W (32),
    .ADDR_W (5)
  ) dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .A_Valid  (A_Valid),
    .A_Rd     (A_Rd),
    .A_Data   (A_Data),
    .A_Ready  (A_Ready),
    .B_Valid  (B_Valid),
    .B_Rd     (B_Rd),
    .B_Data   (B_Data),
    .B_Ready  (B_Ready),
    .RegWrite (RegWrite),
    .RD       (RD),
    .WData    (WData),
    .Pending  (Pending)
  );

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  // One clock cycle: drive, check outputs against the model, clock, update model.
  task automatic step(
    input logic        rst,
    input logic        av,
    input logic [4:0]  ar,
    input logic [31:0] ad,
    input logic        bv,
    input logic [4:0]  br,
    input logic [31:0] bd
  );
    logic        e_rw, e_ar, e_br;
    logic [4:0]  e_rd;
    logic [31:0] e_wd, e_pend;
    Reset   = rst;
    A_Valid = av;
    A_Rd    = ar;
    A_Data  = ad;
    B_Valid = bv;
    B_Rd    = br;
    B_Data  = bd;
    #1;
    e_rw   = !rst && (q.size() != 0);
    e_rd   = e_rw ? q[0].rd : 5'd0;
    e_wd   = e_rw ? q[0].d : 32'd0;
    e_ar   = !rst && (q.size() <= 3);
    e_br   = !rst && (q.size() <= 2);
    e_pend = 32'd0;
    if (!rst)
      foreach (q[i]) e_pend[q[i].rd] = 1'b1;
    chk("RegWrite", {31'd0, RegWrite}, {31'd0, e_rw});
    chk("RD",       {27'd0, RD},       {27'd0, e_rd});
    chk("WData",    WData,             e_wd);
    chk("Pending",  Pending,           e_pend);
    chk("A_Ready",  {31'd0, A_Ready},  {31'd0, e_ar});
    chk("B_Ready",  {31'd0, B_Ready},  {31'd0, e_br});
    chk("QueueLen", {31'd0, q.size() <= 4}, 32'd1);
    @(posedge Clk);
    if (rst) begin
      q.delete();
    end else begin
      if (q.size() != 0) void'(q.pop_front());
      if (av && e_ar && ar != 5'd0)
        q.push_back('{rd: ar, d: ad});
      if (bv && e_br && br != 5'd0)
        q.push_back('{rd: br, d: bd});
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  initial begin
    Reset   = 1'b1;
    A_Valid = 1'b0;
    B_Valid = 1'b0;
    A_Rd    = 5'd0;
    B_Rd    = 5'd0;
    A_Data  = 32'd0;
    B_Data  = 32'd0;
    @(posedge Clk);
    #1;
    step(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    step(1'b1, 1'b1, 5'd7, 32'd1, 1'b1, 5'd8, 32'd2);
    idle(1);

    // Single A write
    step(1'b0, 1'b1, 5'd5, 32'h1234_5678, 1'b0, 5'd0, 32'd0);
    idle(2);

    // Same-cycle A and B to one register
    step(1'b0, 1'b1, 5'd3, 32'hA, 1'b1, 5'd3, 32'hB);
    idle(3);

    // Sustained A with bursts of B
    for (int i = 0; i < 12; i++)
      step(1'b0, 1'b1, 5'(i + 1), 32'h100 + i,
           1'b1, 5'(i + 13), 32'h200 + i);
    idle(5);

    // Rd==0 is swallowed
    step(1'b0, 1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, 5'd0, 32'd0);
    idle(2);

    // Pointer wrap with double pushes
    step(1'b0, 1'b1, 5'd1, 32'h11, 1'b0, 5'd0, 32'd0);
    idle(1);
    step(1'b0, 1'b1, 5'd2, 32'h22, 1'b1, 5'd9, 32'h33);
    step(1'b0, 1'b1, 5'd4, 32'h44, 1'b1, 5'd6, 32'h55);
    step(1'b0, 1'b1, 5'd10, 32'h66, 1'b1, 5'd11, 32'h77);
    idle(5);

    // Reset with three entries queued
    step(1'b0, 1'b1, 5'd12, 32'hC0, 1'b1, 5'd13, 32'hC1);
    step(1'b0, 1'b1, 5'd14, 32'hC2, 1'b1, 5'd15, 32'hC3);
    step(1'b1, 1'b1, 5'd16, 32'hC4, 1'b1, 5'd17, 32'hC5);
    idle(4);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      logic [4:0] ra, rb;
      ra = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      rb = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      step(($urandom_range(0, 60) == 0),
           ($urandom_range(0, 3) != 0), ra, $urandom,
           ($urandom_range(0, 2) != 0), rb, $urandom);
    end
    idle(6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
